// File: rtl/vga_pkg.sv
// Shared VGA timing: default 640x480 geometry, derived totals and sync windows,
// plus the coordinate type used by both axis counters.
package vga_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int H_VISIBLE_D = 640;
   localparam int H_FRONT_D   = 24;
   localparam int H_SYNC_D    = 40;
   localparam int H_BACK_D    = 128;
   localparam int H_TOTAL_D   = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
   localparam int H_SYNC_LO_D = H_VISIBLE_D + H_FRONT_D;
   localparam int H_SYNC_HI_D = H_SYNC_LO_D + H_SYNC_D;

   localparam int V_VISIBLE_D = 480;
   localparam int V_FRONT_D   = 9;
   localparam int V_SYNC_D    = 3;
   localparam int V_BACK_D    = 28;
   localparam int V_TOTAL_D   = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;
   localparam int V_SYNC_LO_D = V_VISIBLE_D + V_FRONT_D;
   localparam int V_SYNC_HI_D = V_SYNC_LO_D + V_SYNC_D;

   // Half-open window test [lo, hi) used for sync pulse decode.
   function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with terminal-count flag and sync-window decode.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter coord_t LAST    = coord_t'(H_TOTAL_D - 1),
   parameter coord_t SYNC_LO = coord_t'(H_SYNC_LO_D),
   parameter coord_t SYNC_HI = coord_t'(H_SYNC_HI_D)
) (
   input  logic   clock,
   input  logic   resetb,
   input  logic   advance,
   output coord_t count,
   output logic   wrap,
   output logic   in_sync
);

   coord_t count_r;

   // Axis position: steps on advance, returns to zero after LAST.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         count_r <= '0;
      end else if (advance) begin
         count_r <= (count_r == LAST) ? '0 : count_r + coord_t'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign count   = count_r;
   assign wrap    = (count_r == LAST);
   assign in_sync = in_window(count_r, SYNC_LO, SYNC_HI);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: x/y counters, registered active-low syncs and
// blanked pixel output, one pixel_ce tick behind the counters.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_D,
   parameter int H_FRONT   = H_FRONT_D,
   parameter int H_SYNC    = H_SYNC_D,
   parameter int H_BACK    = H_BACK_D,
   parameter int V_VISIBLE = V_VISIBLE_D,
   parameter int V_FRONT   = V_FRONT_D,
   parameter int V_SYNC    = V_SYNC_D,
   parameter int V_BACK    = V_BACK_D
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       pixel_ce,
   input  logic [2:0] rgb_in,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb,
   output logic       line_start,
   output logic       frame_start
);

   localparam int     H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int     V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
   localparam coord_t H_SYNC_LO = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t H_SYNC_HI = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t V_SYNC_LO = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t V_SYNC_HI = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);

   coord_t     x_s;
   coord_t     y_s;
   logic       h_wrap_s;
   logic       v_wrap_s;
   logic       h_in_sync_s;
   logic       v_in_sync_s;
   logic       v_advance_s;
   logic       active_s;
   logic       hsync_r;
   logic       vsync_r;
   logic [2:0] rgb_r;

   vga_axis_counter #(
      .LAST    (H_LAST),
      .SYNC_LO (H_SYNC_LO),
      .SYNC_HI (H_SYNC_HI)
   ) u_h_axis (
      .clock   (clock),
      .resetb  (resetb),
      .advance (pixel_ce),
      .count   (x_s),
      .wrap    (h_wrap_s),
      .in_sync (h_in_sync_s)
   );

   // The vertical axis only moves on the tick that ends a line.
   assign v_advance_s = pixel_ce & h_wrap_s;

   vga_axis_counter #(
      .LAST    (V_LAST),
      .SYNC_LO (V_SYNC_LO),
      .SYNC_HI (V_SYNC_HI)
   ) u_v_axis (
      .clock   (clock),
      .resetb  (resetb),
      .advance (v_advance_s),
      .count   (y_s),
      .wrap    (v_wrap_s),
      .in_sync (v_in_sync_s)
   );

   assign active_s = (x_s < H_VIS_END) && (y_s < V_VIS_END);

   // Capture sync and blanked colour for the pixel the counters point at.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         hsync_r <= 1'b1;
         vsync_r <= 1'b1;
         rgb_r   <= 3'b000;
      end else if (pixel_ce) begin
         hsync_r <= ~h_in_sync_s;
         vsync_r <= ~v_in_sync_s;
         rgb_r   <= active_s ? rgb_in : 3'b000;
      end else begin
         hsync_r <= hsync_r;
         vsync_r <= vsync_r;
         rgb_r   <= rgb_r;
      end
   end

   assign x           = x_s;
   assign y           = y_s;
   assign active      = active_s;
   assign hsync       = hsync_r;
   assign vsync       = vsync_r;
   assign rgb         = rgb_r;
   assign line_start  = v_advance_s;
   assign frame_start = v_advance_s & v_wrap_s;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken 16x12 raster.
module tb_vga_sync_gen;

   localparam int HV = 8, HF = 2, HS = 3, HB = 3;   // H_TOTAL 16, hsync x in [10,13)
   localparam int VV = 6, VF = 2, VS = 2, VB = 2;   // V_TOTAL 12, vsync y in [8,10)
   localparam int HT = 16, VT = 12;

   logic       clock = 1'b0;
   logic       resetb;
   logic       pixel_ce;
   logic [2:0] rgb_in;
   logic [9:0] x, y;
   logic       active, hsync, vsync, line_start, frame_start;
   logic [2:0] rgb;

   int n_checks = 0;
   int n_pass   = 0;

   vga_sync_gen #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
   ) dut (
      .clock       (clock),
      .resetb      (resetb),
      .pixel_ce    (pixel_ce),
      .rgb_in      (rgb_in),
      .x           (x),
      .y           (y),
      .active      (active),
      .hsync       (hsync),
      .vsync       (vsync),
      .rgb         (rgb),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   initial begin
      int         ex, ey, px, py;
      logic       pact, found;
      logic [2:0] prgb;
      int         hlow, vlow, ls_cnt, fs_cnt;
      logic [9:0] sx, sy;
      logic       sh, sv;
      logic [2:0] srgb;

      resetb = 1'b0; pixel_ce = 1'b0; rgb_in = 3'b000;
      repeat (3) @(negedge clock);
      pixel_ce = 1'b1; rgb_in = 3'b111;
      @(negedge clock);
      check_val("rst_x", x, 0);
      check_val("rst_y", y, 0);
      check_val("rst_hsync", hsync, 1);
      check_val("rst_vsync", vsync, 1);
      check_val("rst_rgb", rgb, 0);
      check_val("rst_line_start", line_start, 0);
      check_val("rst_frame_start", frame_start, 0);

      // One full frame with pixel_ce held high.
      resetb = 1'b1;
      ex = 0; ey = 0; px = 0; py = 0; pact = 1'b0; prgb = 3'b000;
      hlow = 0; vlow = 0; ls_cnt = 0; fs_cnt = 0;
      for (int k = 0; k <= HT*VT; k++) begin
         if (k > 0) begin
            @(negedge clock);
            check_val("hsync", hsync, (px >= 10 && px < 13) ? 0 : 1);
            check_val("vsync", vsync, (py >= 8 && py < 10) ? 0 : 1);
            check_val("rgb", rgb, pact ? prgb : 3'b000);
            if (!hsync) hlow++;
            if (!vsync) vlow++;
         end
         if (k < HT*VT) begin
            check_val("x", x, ex);
            check_val("y", y, ey);
            check_val("active", active, (ex < 8 && ey < 6) ? 1 : 0);
            check_val("line_start", line_start, (ex == 15) ? 1 : 0);
            check_val("frame_start", frame_start, (ex == 15 && ey == 11) ? 1 : 0);
            if (line_start) ls_cnt++;
            if (frame_start) fs_cnt++;
            px = ex; py = ey;
            pact = (ex < 8 && ey < 6);
            prgb = 3'(k);
            rgb_in = prgb;
            if (ex == HT-1) begin
               ex = 0;
               ey = (ey == VT-1) ? 0 : ey + 1;
            end else begin
               ex = ex + 1;
            end
         end
      end
      check_val("wrap_x", x, 0);
      check_val("wrap_y", y, 0);
      check_val("hsync_low_per_frame", hlow, 36);
      check_val("vsync_low_per_frame", vlow, 32);
      check_val("line_starts", ls_cnt, 12);
      check_val("frame_starts", fs_cnt, 1);

      // pixel_ce toggling: every ce=0 cycle must hold all state.
      sx = x; sy = y; sh = hsync; sv = vsync; srgb = rgb;
      for (int j = 0; j < 64; j++) begin
         if (j > 0) begin
            @(negedge clock);
            if (!pixel_ce) begin
               check_val("hold_x", x, sx);
               check_val("hold_y", y, sy);
               check_val("hold_hsync", hsync, sh);
               check_val("hold_vsync", vsync, sv);
               check_val("hold_rgb", rgb, srgb);
            end
         end
         sx = x; sy = y; sh = hsync; sv = vsync; srgb = rgb;
         pixel_ce = (j % 2 == 1);
         #1;
         if (!pixel_ce) begin
            check_val("idle_line_start", line_start, 0);
            check_val("idle_frame_start", frame_start, 0);
         end
      end
      @(negedge clock);
      check_val("toggle_x", x, 0);
      check_val("toggle_y", y, 2);

      // Reset asserted while both syncs are low.
      pixel_ce = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clock);
         if (x == 10'd13 && y == 10'd8) found = 1'b1;
      end
      check_val("seek_sync", found, 1);
      check_val("pre_rst_hsync", hsync, 0);
      check_val("pre_rst_vsync", vsync, 0);
      #2 resetb = 1'b0;
      #1;
      check_val("mid_rst_hsync", hsync, 1);
      check_val("mid_rst_vsync", vsync, 1);
      check_val("mid_rst_rgb", rgb, 0);
      check_val("mid_rst_x", x, 0);
      check_val("mid_rst_y", y, 0);
      @(negedge clock);
      resetb = 1'b1; rgb_in = 3'b110;
      #1;
      check_val("restart_frame_start", frame_start, 0);
      check_val("restart_x", x, 0);
      @(negedge clock);
      check_val("restart_x1", x, 1);
      check_val("restart_rgb", rgb, 3'b110);
      check_val("restart_hsync", hsync, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
